mport_ram: RTL and testbench

MPORT_RAM -- requirements
Module: mport_ram

---
 rtl/mport_ram_pkg.sv | 28 ++
 rtl/mport_ram_rr_arbiter.sv | 47 ++++
 rtl/mport_ram.sv | 182 ++++++++++++++++++
 tb/tb_mport_ram.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mport_ram_pkg.sv
`default_nettype none
// ============================================================================
// mport_ram_pkg - size encodings, FSM state type and lane helper for mport_ram.
// Rev 1.0
// ============================================================================
package mport_ram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Byte lanes touched by an access; lo is already aligned to the size.
    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: lane_mask = 4'b0001 << lo;
            SZ_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mport_ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter - one-hot round-robin grant, priority starts after the last winner.
// Rev 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last_q;
    int            win;
    int            best;

    // Distance 0 is the port right after the last winner.
    always_comb begin
        win   = 0;
        best  = N;
        grant = '0;
        for (int j = 0; j < N; j++) begin
            if (req[j] && (((j + N - 1 - int'(last_q)) % N) < best)) begin
                best = (j + N - 1 - int'(last_q)) % N;
                win  = j;
            end
        end
        for (int j = 0; j < N; j++) begin
            grant[j] = req[j] && (j == win);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            last_q <= PW'(N - 1);
        end else if (advance && (|req)) begin
            last_q <= PW'(win);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mport_ram.sv
`default_nettype none
// ============================================================================
// mport_ram - byte-addressed RAM shared by NPORT requesters, round-robin served.
// Define MPORT_RAM_ERR_EN to flag range/size/alignment errors.  Rev 1.0
// ============================================================================
module mport_ram
    import mport_ram_pkg::*;
#(
    parameter int          NPORT = 2,
    parameter int          AW    = 12,
    parameter logic [31:0] BASE  = 32'h1000,
    parameter int          WAIT  = 1,
    parameter string       INIT  = ""
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic [NPORT-1:0]       valid,
    input  logic [NPORT-1:0]       write,
    input  logic [32*NPORT-1:0]    addr,
    input  logic [2*NPORT-1:0]     size,
    input  logic [32*NPORT-1:0]    wdata,
    output logic [NPORT-1:0]       ready,
    output logic [31:0]            rdata,
    output logic [NPORT-1:0]       err
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]       mem_q [DEPTH];
    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [NPORT-1:0] gnt_q, grant, ready_q, ready_d;
    logic             write_q;
    logic [31:0]      addr_q, wdata_q, rdata_q, rdata_d;
    logic [1:0]       size_q;
    logic             advance;

    logic             sel_write;
    logic [31:0]      sel_addr, sel_wdata;
    logic [1:0]       sel_size;

    assign advance = (state_q == ST_IDLE) && (|valid);

    rr_arbiter #(.N(NPORT)) u_arb (
        .clk     (clk),
        .rstb    (rstb),
        .req     (valid),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_size  = '0;
        sel_wdata = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (grant[p]) begin
                sel_write = write[p];
                sel_addr  = addr[32*p +: 32];
                sel_size  = size[2*p +: 2];
                sel_wdata = wdata[32*p +: 32];
            end
        end
    end

    logic [AW-1:0] off;
    logic [1:0]    lo;
    logic [1:0]    eff_size;
    logic          acc_err;

`ifdef MPORT_RAM_ERR_EN
    logic [31:0] off_full;
    assign off_full = addr_q - BASE;
    assign off      = off_full[AW-1:0];
    assign eff_size = size_q;
    assign lo       = off[1:0];
    assign acc_err  = (addr_q < BASE) || ((off_full >> AW) != 32'd0) || (size_q == 2'd3)
                    || ((size_q == SZ_HALF) && addr_q[0])
                    || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
`else
    // Offset wraps modulo the array; low bits are forced to the access size.
    assign off      = AW'(addr_q - BASE);
    assign eff_size = (size_q == 2'd3) ? SZ_WORD : size_q;
    assign lo       = (eff_size == SZ_BYTE) ? off[1:0] :
                      (eff_size == SZ_HALF) ? {off[1], 1'b0} : 2'b00;
    assign acc_err  = 1'b0;
`endif

    logic [AW-3:0] widx;
    logic [3:0]    lanes;
    logic [31:0]   rword, rsh, rd_val, wsh;

    assign widx   = off[AW-1:2];
    assign lanes  = lane_mask(eff_size, lo);
    assign rword  = {mem_q[{widx, 2'd3}], mem_q[{widx, 2'd2}], mem_q[{widx, 2'd1}], mem_q[{widx, 2'd0}]};
    assign rsh    = rword >> {lo, 3'b000};
    assign rd_val = (eff_size == SZ_BYTE) ? {24'd0, rsh[7:0]} :
                    (eff_size == SZ_HALF) ? {16'd0, rsh[15:0]} : rsh;
    assign wsh    = wdata_q << {lo, 3'b000};

    // Array is not reset; an access abandoned by reset never reaches RESP.
    always @(posedge clk) begin
        if ((state_q == ST_RESP) && write_q && !acc_err) begin
            for (int k = 0; k < 4; k++) begin
                if (lanes[k]) mem_q[{widx, 2'(k)}] <= wsh[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = '0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|valid) begin
                    if (WAIT == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = 4'(WAIT - 1);
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = gnt_q;
                rdata_d = (write_q || acc_err) ? 32'd0 : rd_val;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= '0;
            rdata_q <= 32'd0;
            gnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            if (advance) begin
                gnt_q   <= grant;
                write_q <= sel_write;
                addr_q  <= sel_addr;
                size_q  <= sel_size;
                wdata_q <= sel_wdata;
            end
        end
    end

`ifdef MPORT_RAM_ERR_EN
    logic [NPORT-1:0] err_q;
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)                              err_q <= '0;
        else if ((state_q == ST_RESP) && acc_err) err_q <= gnt_q;
        else                                    err_q <= '0;
    end
    assign err = err_q;
`else
    assign err = '0;
`endif

    assign ready = ready_q;
    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mport_ram.sv
`default_nettype none
// ============================================================================
// tb_mport_ram - randomized self-checking bench against a byte-array model.
// Rev 1.0
// ============================================================================
module tb_mport_ram;

    localparam int          NP    = 2;
    localparam int          AW    = 12;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h1000;
    localparam int          WAIT  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstb;
    logic [NP-1:0]     valid, write, ready, err;
    logic [32*NP-1:0]  addr, wdata;
    logic [2*NP-1:0]   size;
    logic [31:0]       rdata;

    mport_ram #(.NPORT(NP), .AW(AW), .BASE(BASE), .WAIT(WAIT), .INIT("")) dut (
        .clk(clk), .rstb(rstb), .valid(valid), .write(write), .addr(addr),
        .size(size), .wdata(wdata), .ready(ready), .rdata(rdata), .err(err)
    );

    logic [3:0]   v4, w4, r4, e4;
    logic [127:0] a4, wd4;
    logic [7:0]   s4;
    logic [31:0]  rd4;

    mport_ram #(.NPORT(4), .AW(AW), .BASE(BASE), .WAIT(0), .INIT("")) dut4 (
        .clk(clk), .rstb(rstb), .valid(v4), .write(w4), .addr(a4),
        .size(s4), .wdata(wd4), .ready(r4), .rdata(rd4), .err(e4)
    );

    int         n_chk  = 0;
    int         n_pass = 0;
    int         rr_last;
    logic [7:0] mdl [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Reference: plain byte array, little-endian, addressing rules applied directly.
    task automatic model(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e);
        logic [31:0] off;
        int          nb;
        off = a - BASE;
        rd  = 32'd0;
        e   = 1'b0;
`ifdef MPORT_RAM_ERR_EN
        if ((a < BASE) || (off >= DEPTH) || (sz == 2'd3) || ((sz == 2'd1) && a[0])
            || ((sz == 2'd2) && (a[1:0] != 2'b00))) begin
            e = 1'b1;
            return;
        end
`endif
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = off % DEPTH;
        off = off - (off % nb);
        for (int k = 0; k < nb; k++) begin
            if (wr) mdl[off + k] = wd[8*k +: 8];
            else    rd = rd | (32'(mdl[off + k]) << (8 * k));
        end
    endtask

    task automatic access(input int p, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, output logic [31:0] rd, output logic e,
                          output int lat);
        @(negedge clk);
        write[p]            = wr;
        addr[32*p +: 32]    = a;
        size[2*p +: 2]      = sz;
        wdata[32*p +: 32]   = wd;
        valid[p]            = 1'b1;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (ready[p]) break;
        end
        valid[p] = 1'b0;
        rd = rdata;
        e  = err[p];
    endtask

    task automatic run(input string tag, input int p, input bit wr, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] rd, erd;
        logic        e, ee;
        int          lat;
        model(wr, a, sz, wd, erd, ee);
        access(p, wr, a, sz, wd, rd, e, lat);
        chk({tag, "_rdata"}, rd, erd);
        chk({tag, "_err"}, 32'(e), 32'(ee));
        chk({tag, "_lat"}, 32'(lat), 32'(WAIT + 2));
        rr_last = p;
    endtask

    // Both ports request together; expect the port after the last winner first.
    task automatic round(input string tag);
        int got[$];
        int cyc;
        int exp_first;
        exp_first = (rr_last + 1) % NP;
        cyc = 0;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            write[p]          = 1'b0;
            addr[32*p +: 32]  = BASE + 32'h10;
            size[2*p +: 2]    = 2'd2;
            valid[p]          = 1'b1;
        end
        while ((got.size() < NP) && (cyc < 50)) begin
            @(negedge clk);
            cyc++;
            for (int p = 0; p < NP; p++) begin
                if (ready[p]) begin
                    got.push_back(p);
                    valid[p] = 1'b0;
                end
            end
        end
        valid = '0;
        chk({tag, "_served"}, 32'(got.size()), 32'(NP));
        if (got.size() == NP) begin
            chk({tag, "_first"}, 32'(got[0]), 32'(exp_first));
            chk({tag, "_second"}, 32'(got[1]), 32'(1 - exp_first));
        end
        rr_last = 1 - exp_first;
    endtask

    initial begin
        int          cnt4 [4];
        int          overlap;
        int          pulses;
        logic [31:0] a;
        int          sel;

        rstb  = 1'b0;
        valid = '0; write = '0; addr = '0; size = '0; wdata = '0;
        v4    = '0; w4 = '0; a4 = {4{BASE}}; s4 = {4{2'b10}}; wd4 = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        rstb    = 1'b1;
        rr_last = NP - 1;

        for (int i = 0; i < 256; i++) run("fill", i % NP, 1'b1, BASE + 32'(4 * i), 2'd2, $urandom);

        run("w1100", 0, 1'b1, 32'h1100, 2'd2, 32'h73686974);
        run("r1100", 0, 1'b0, 32'h1100, 2'd2, 32'd0);
        chk("r1100_const", rdata, 32'h73686974);

        run("w1200", 0, 1'b1, 32'h1200, 2'd2, 32'd0);
        run("wb1203", 0, 1'b1, 32'h1203, 2'd0, 32'h41);
        run("r1200", 0, 1'b0, 32'h1200, 2'd2, 32'd0);
        chk("r1200_const", rdata, 32'h41000000);
        run("rh1202", 0, 1'b0, 32'h1202, 2'd1, 32'd0);
        chk("rh1202_const", rdata, 32'h00004100);

        run("r2000", 0, 1'b0, 32'h2000, 2'd2, 32'd0);
        run("rh1101", 0, 1'b0, 32'h1101, 2'd1, 32'd0);
        run("r1100_again", 1, 1'b0, 32'h1100, 2'd2, 32'd0);

        for (int i = 0; i < 4; i++) round($sformatf("rr%0d", i));

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 7);
            a   = BASE + 32'($urandom_range(0, 1023));
            if (sel == 0)      a = a + 32'h1000 * 32'($urandom_range(1, 3));
            else if (sel == 1) a = a - 32'h1000;
            run("rand", $urandom_range(0, 1), 1'($urandom_range(0, 1)), a,
                2'($urandom_range(0, 3)), $urandom);
        end

        // Four ports, zero wait, continuous requests.
        for (int p = 0; p < 4; p++) cnt4[p] = 0;
        overlap = 0;
        @(negedge clk);
        v4 = 4'hF;
        for (int c = 0; c < 46; c++) begin
            @(negedge clk);
            if (c == 39) v4 = 4'h0;
            if ($countones(r4) > 1) overlap++;
            for (int p = 0; p < 4; p++) if (r4[p]) cnt4[p]++;
        end
        for (int p = 0; p < 4; p++) chk($sformatf("starve_p%0d", p), 32'(cnt4[p]), 32'd5);
        chk("starve_overlap", 32'(overlap), 32'd0);

        run("pre1300_w", 0, 1'b1, 32'h1300, 2'd2, 32'hA5A51234);
        run("pre1300_r", 0, 1'b0, 32'h1300, 2'd2, 32'd0);
        @(negedge clk);
        write[0] = 1'b1; addr[31:0] = 32'h1300; size[1:0] = 2'd2; wdata[31:0] = 32'hDEADBEEF;
        valid[0] = 1'b1;
        @(negedge clk);
        rstb     = 1'b0;
        valid[0] = 1'b0;
        #1;
        chk("rst_async_rdata", rdata, 32'd0);
        chk("rst_async_ready", 32'(ready), 32'd0);
        pulses = 0;
        repeat (4) @(negedge clk) if (ready != '0) pulses++;
        rstb    = 1'b1;
        rr_last = NP - 1;
        repeat (3) @(negedge clk) if (ready != '0) pulses++;
        chk("rst_no_ready", 32'(pulses), 32'd0);
        round("post_rst");
        run("post_rst_1300", 0, 1'b0, 32'h1300, 2'd2, 32'd0);
        chk("post_rst_1300_const", rdata, 32'hA5A51234);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
